// File: rtl/scroll_ctrl.sv
// Scroll chain sequencer: emits a latched message MSB-first, one bit per step, then flushes or loops.
// Optional build macro SCROLL_PAUSE_EN adds in_PAUSE, which freezes stepping in RUN and FLUSH.
module scroll_ctrl #(
   parameter int MSG_W     = 32,
   parameter int DIV       = 25000000,
   parameter int CHAIN_LEN = 16
) (
   input  logic                       in_CLK,
   input  logic                       in_RST,
   input  logic                       in_START,
   input  logic                       in_LOOP,
   input  logic [MSG_W-1:0]           in_MSG,
`ifdef SCROLL_PAUSE_EN
   input  logic                       in_PAUSE,
`endif
   output logic                       out_SER_D,
   output logic                       out_SHIFT,
   output logic [$clog2(MSG_W)-1:0]   out_POS,
   output logic                       out_BUSY,
   output logic                       out_DONE
);

   localparam int POS_W = $clog2(MSG_W);
   localparam int PW    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int FW    = (CHAIN_LEN > 0) ? $clog2(CHAIN_LEN + 1) : 1;

   localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV - 1);
   localparam logic [POS_W-1:0] POS_LAST   = POS_W'(MSG_W - 1);
   localparam logic [FW-1:0]    FLUSH_LEN  = FW'(CHAIN_LEN);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_FLUSH,
      S_DONE
   } state_e;

   state_e             state_q;
   logic [PW-1:0]      presc_q;
   logic [POS_W-1:0]   idx_q;
   logic [FW-1:0]      flush_q;
   logic [MSG_W-1:0]   shadow_q;
   logic               ser_d_q;
   logic               shift_q;
   logic [POS_W-1:0]   pos_q;
   logic               busy_q;
   logic               done_q;
   logic               stall;

`ifdef SCROLL_PAUSE_EN
   assign stall = in_PAUSE;
`else
   assign stall = 1'b0;
`endif

   always_ff @(posedge in_CLK) begin
      if (in_RST) begin
         state_q  <= S_IDLE;
         presc_q  <= '0;
         idx_q    <= '0;
         flush_q  <= '0;
         shadow_q <= '0;
         ser_d_q  <= 1'b0;
         shift_q  <= 1'b0;
         pos_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         // Strobe and done are single-cycle pulses; they only rise on the cycle a step completes.
         shift_q <= 1'b0;
         ser_d_q <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               pos_q <= '0;
               if (in_START) begin
                  shadow_q <= in_MSG;
                  busy_q   <= 1'b1;
                  state_q  <= S_LOAD;
               end
            end
            S_LOAD: begin
               presc_q <= '0;
               idx_q   <= '0;
               flush_q <= '0;
               pos_q   <= '0;
               state_q <= S_RUN;
            end
            S_RUN: begin
               if (!stall) begin
                  if (presc_q == PRESC_LAST) begin
                     presc_q  <= '0;
                     shift_q  <= 1'b1;
                     ser_d_q  <= shadow_q[MSG_W-1];
                     shadow_q <= {shadow_q[MSG_W-2:0], shadow_q[MSG_W-1]};
                     pos_q    <= idx_q;
                     if (idx_q == POS_LAST) begin
                        // A full rotation has restored the shadow, so looping needs no reload.
                        idx_q <= '0;
                        if (!in_LOOP) begin
                           flush_q <= '0;
                           state_q <= S_FLUSH;
                        end
                     end else begin
                        idx_q <= idx_q + 1'b1;
                     end
                  end else begin
                     presc_q <= presc_q + 1'b1;
                  end
               end
            end
            S_FLUSH: begin
               pos_q <= '0;
               if (!stall) begin
                  if (presc_q == PRESC_LAST) begin
                     presc_q <= '0;
                     if (flush_q == FLUSH_LEN) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                     end else begin
                        shift_q <= 1'b1;
                        flush_q <= flush_q + 1'b1;
                     end
                  end else begin
                     presc_q <= presc_q + 1'b1;
                  end
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign out_SER_D = ser_d_q;
   assign out_SHIFT = shift_q;
   assign out_POS   = pos_q;
   assign out_BUSY  = busy_q;
   assign out_DONE  = done_q;

endmodule

// File: tb/tb_scroll_ctrl.sv
// Bench for scroll_ctrl: two instances (step divider 4 and 1) share stimulus; a timing model
// of the strobe train predicts every strobe cycle, bit and position plus the done pulse.
module tb_scroll_ctrl;

   localparam int MSG_W     = 8;
   localparam int CHAIN_LEN = 4;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       in_RST   = 1'b1;
   logic       in_START = 1'b0;
   logic       in_LOOP  = 1'b0;
   logic [7:0] in_MSG   = 8'h00;
`ifdef SCROLL_PAUSE_EN
   logic       in_PAUSE = 1'b0;
`endif
   logic       sel1     = 1'b0;
   logic       start4, start1;

   logic       ser4, shift4, busy4, done4;
   logic [2:0] pos4;
   logic       ser1, shift1, busy1, done1;
   logic [2:0] pos1;
   logic       ser_d, shift, busy, done;
   logic [2:0] pos;

   assign start4 = in_START & ~sel1;
   assign start1 = in_START & sel1;

   scroll_ctrl #(.MSG_W(MSG_W), .DIV(4), .CHAIN_LEN(CHAIN_LEN)) dut4 (
      .in_CLK(clk), .in_RST(in_RST), .in_START(start4), .in_LOOP(in_LOOP), .in_MSG(in_MSG),
`ifdef SCROLL_PAUSE_EN
      .in_PAUSE(in_PAUSE),
`endif
      .out_SER_D(ser4), .out_SHIFT(shift4), .out_POS(pos4), .out_BUSY(busy4), .out_DONE(done4)
   );

   scroll_ctrl #(.MSG_W(MSG_W), .DIV(1), .CHAIN_LEN(CHAIN_LEN)) dut1 (
      .in_CLK(clk), .in_RST(in_RST), .in_START(start1), .in_LOOP(in_LOOP), .in_MSG(in_MSG),
`ifdef SCROLL_PAUSE_EN
      .in_PAUSE(in_PAUSE),
`endif
      .out_SER_D(ser1), .out_SHIFT(shift1), .out_POS(pos1), .out_BUSY(busy1), .out_DONE(done1)
   );

   always_comb begin
      if (sel1) begin
         ser_d = ser1; shift = shift1; busy = busy1; done = done1; pos = pos1;
      end else begin
         ser_d = ser4; shift = shift4; busy = busy4; done = done4; pos = pos4;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: strobe k lands DIV+1 cycles after START is sampled plus k steps of DIV,
   // shifted by any pause that began after an earlier strobe.
   typedef struct {
      int   cyc;
      logic bit_v;
      int   pos;
   } strobe_t;

   strobe_t exp_q[$];
   int      exp_done;
   int      exp_total;

   task automatic build_model(input logic [7:0] msg, input bit loop_en, input int drop_k,
                              input int pause_k, input int pause_len, input int div, input int samp);
      int passes;
      strobe_t s;
      passes    = loop_en ? (drop_k / MSG_W + 1) : 1;
      exp_total = passes * MSG_W + CHAIN_LEN;
      exp_q.delete();
      for (int k = 0; k < exp_total; k++) begin
         s.cyc = samp + div + 1 + k * div + ((pause_k >= 0 && k > pause_k) ? pause_len : 0);
         if (k < passes * MSG_W) begin
            s.bit_v = msg[MSG_W - 1 - (k % MSG_W)];
            s.pos   = k % MSG_W;
         end else begin
            s.bit_v = 1'b0;
            s.pos   = 0;
         end
         exp_q.push_back(s);
      end
      exp_done = exp_q[exp_q.size() - 1].cyc + div;
   endtask

   task automatic do_reset();
      in_RST   = 1'b1;
      in_START = 1'b0;
      @(negedge clk);
      in_RST   = 1'b0;
      @(negedge clk);
   endtask

   task automatic run_scn(input logic [7:0] msg, input bit use1, input bit loop_en,
                          input int drop_k, input int busy_k, input int pause_k, input int pause_len,
                          input bit hold_start, output int n_strobe, output logic [7:0] first8);
      int      samp;
      int      div;
      bit      start_clr;
      int      pause_left;
      strobe_t e;
      sel1     = use1;
      div      = use1 ? 1 : 4;
      in_MSG   = msg;
      in_LOOP  = loop_en;
      in_START = 1'b1;
      samp     = cyc + 1;
      build_model(msg, loop_en, drop_k, pause_k, pause_len, div, samp);
      @(negedge clk);
      if (!hold_start) in_START = 1'b0;
      n_strobe   = 0;
      first8     = 8'h00;
      start_clr  = 1'b0;
      pause_left = 0;
      for (int t = 0; t < 2000; t++) begin
         if (start_clr) begin
            in_START  = 1'b0;
            start_clr = 1'b0;
         end
         if (pause_left > 0) begin
            pause_left--;
`ifdef SCROLL_PAUSE_EN
            if (pause_left == 0) in_PAUSE = 1'b0;
`endif
         end
         chk("busy", busy, (cyc >= samp && cyc <= exp_done));
         chk("done", done, cyc == exp_done);
         if (shift) begin
            if (exp_q.size() == 0) begin
               chk("strobe_unexpected", n_strobe + 1, exp_total);
            end else begin
               e = exp_q.pop_front();
               chk("strobe_cycle", cyc, e.cyc);
               chk("ser_d", ser_d, e.bit_v);
               chk("pos", pos, e.pos);
            end
            if (n_strobe < 8) first8 = {first8[6:0], ser_d};
            if (n_strobe == drop_k) in_LOOP = 1'b0;
            if (n_strobe == busy_k) begin
               in_START  = 1'b1;
               in_MSG    = 8'hFF;
               start_clr = 1'b1;
            end
            if (n_strobe == pause_k) begin
`ifdef SCROLL_PAUSE_EN
               in_PAUSE = 1'b1;
`endif
               pause_left = pause_len;
            end
            n_strobe++;
         end else begin
            chk("ser_d_idle", ser_d, 1'b0);
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) chk("strobe_missing", shift, 1'b1);
         end
         if (cyc == exp_done + 1) break;
         @(negedge clk);
      end
      chk("strobes_left", exp_q.size(), 0);
      chk("end_cycle", cyc, exp_done + 1);
      if (hold_start) begin
         @(negedge clk);
         chk("reload_busy", busy, 1'b1);
         do_reset();
      end
   endtask

   typedef struct {
      logic [7:0] msg;
      bit         use1;
      bit         loop_en;
      int         drop_k;
      int         busy_k;
      int         exp_n;
      logic [7:0] exp_first8;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int         n;
      logic [7:0] f8;
      int         cnt;
      int         t;
      logic [7:0] rmsg;
      bit         ruse1, rloop;
      int         rdrop, rbusy;

      vecs[0] = '{8'hA5, 1'b0, 1'b0, -1, -1, 12, 8'hA5};
      vecs[1] = '{8'h81, 1'b0, 1'b1,  9, -1, 20, 8'h81};
      vecs[2] = '{8'hA5, 1'b0, 1'b0, -1,  1, 12, 8'hA5};
      vecs[3] = '{8'hA5, 1'b1, 1'b0, -1, -1, 12, 8'hA5};
      vecs[4] = '{8'h3C, 1'b0, 1'b0, -1, -1, 12, 8'h3C};
      vecs[5] = '{8'h5A, 1'b1, 1'b1, 10, 3, 20, 8'h5A};

      // Reset held with START high: everything stays quiet.
      in_RST   = 1'b1;
      in_START = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rst_busy4", busy4, 1'b0);
         chk("rst_shift4", shift4, 1'b0);
         chk("rst_ser4", ser4, 1'b0);
         chk("rst_pos4", pos4, 3'd0);
         chk("rst_done4", done4, 1'b0);
         chk("rst_busy1", busy1, 1'b0);
         chk("rst_shift1", shift1, 1'b0);
      end
      in_RST   = 1'b0;
      in_START = 1'b0;
      @(negedge clk);
      chk("post_rst_busy", busy4, 1'b0);
      chk("post_rst_shift", shift4, 1'b0);

      for (int i = 0; i < 6; i++) begin
         run_scn(vecs[i].msg, vecs[i].use1, vecs[i].loop_en, vecs[i].drop_k, vecs[i].busy_k,
                 -1, 0, 1'b0, n, f8);
         chk("vec_count", n, vecs[i].exp_n);
         chk("vec_bits", f8, vecs[i].exp_first8);
         @(negedge clk);
      end

      // Reset after the third strobe aborts immediately, then a fresh message runs cleanly.
      sel1     = 1'b0;
      in_MSG   = 8'hA5;
      in_LOOP  = 1'b0;
      in_START = 1'b1;
      @(negedge clk);
      in_START = 1'b0;
      cnt = 0;
      t   = 0;
      while (cnt < 3 && t < 100) begin
         @(negedge clk);
         t++;
         if (shift4) cnt++;
      end
      chk("midrun_reached", cnt, 3);
      in_RST = 1'b1;
      @(negedge clk);
      chk("midrst_busy", busy4, 1'b0);
      chk("midrst_shift", shift4, 1'b0);
      chk("midrst_ser", ser4, 1'b0);
      chk("midrst_pos", pos4, 3'd0);
      chk("midrst_done", done4, 1'b0);
      in_RST = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("midrst_quiet_shift", shift4, 1'b0);
         chk("midrst_quiet_busy", busy4, 1'b0);
      end
      run_scn(8'h3C, 1'b0, 1'b0, -1, -1, -1, 0, 1'b0, n, f8);
      chk("midrst_new_count", n, 12);
      chk("midrst_new_bits", f8, 8'h3C);
      @(negedge clk);

      // START held through DONE: reload on the cycle after IDLE.
      run_scn(8'hC3, 1'b1, 1'b0, -1, -1, -1, 0, 1'b1, n, f8);
      chk("hold_count", n, 12);
      chk("hold_bits", f8, 8'hC3);

`ifdef SCROLL_PAUSE_EN
      run_scn(8'hA5, 1'b0, 1'b0, -1, -1, 1, 6, 1'b0, n, f8);
      chk("pause_count", n, 12);
      chk("pause_bits", f8, 8'hA5);
      @(negedge clk);
      run_scn(8'h96, 1'b1, 1'b0, -1, -1, 5, 3, 1'b0, n, f8);
      chk("pause1_count", n, 12);
      @(negedge clk);
`endif

      for (int i = 0; i < 8; i++) begin
         rmsg  = 8'($urandom_range(0, 255));
         ruse1 = 1'($urandom_range(0, 1));
         rloop = 1'($urandom_range(0, 1));
         rdrop = $urandom_range(0, 1) * 8 + $urandom_range(0, 6);
         rbusy = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 10) : -1;
         run_scn(rmsg, ruse1, rloop, rloop ? rdrop : -1, rbusy, -1, 0, 1'b0, n, f8);
         chk("rand_bits", f8, rmsg);
         @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

endmodule
